xlib_dma_rc_arb: RTL and testbench

//  Burst-granular round-robin arbiter sharing one read bus (biu_* burst port) among N

---
 rtl/xlib_dma_rc_arb.sv | 204 ++++++++++++++++++++
 tb/tb_xlib_dma_rc_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlib_dma_rc_arb.sv
// xlib_dma_rc_arb
// Burst-granular round-robin arbiter: N DMA read engines share one burst read
// port. A channel owns the bus from grant until its eob beat is accepted; the
// owner of every issued burst is logged in a tag FIFO so that in-order read
// responses can be steered back, 2**BL beats per tag.
module xlib_dma_rc_arb #(
    parameter int N         = 2,
    parameter int AW        = 32,
    parameter int BL        = 4,
    parameter int BLEN_TYPE = 0,
    parameter int OW        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N*AW-1:0]               m_adr,
    input  logic [N*(BL-BLEN_TYPE+1)-1:0] m_len,
    input  logic [N-1:0]                  m_sob,
    input  logic [N-1:0]                  m_eob,
    input  logic [N-1:0]                  m_val,
    output logic [N-1:0]                  m_rdy,
    output logic [N-1:0]                  m_rsp_val,
    output logic [AW-1:0]                 s_adr,
    output logic [BL-BLEN_TYPE:0]         s_len,
    output logic                          s_sob,
    output logic                          s_eob,
    output logic                          s_val,
    input  logic                          s_rdy,
    input  logic                          s_rsp_val,
    output logic                          busy,
    output logic                          err
);

    localparam int LW    = BL - BLEN_TYPE + 1;
    localparam int GW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 2 ** OW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [OW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW:0]   level_q, level_d;
    logic [BL-1:0] rsp_cnt_q, rsp_cnt_d;
    logic          err_q, err_d;

    // Owner index of each outstanding burst, oldest at rd_ptr_q.
    logic [GW-1:0] tag_mem [DEPTH];

    logic [AW-1:0] adr_a [N];
    logic [LW-1:0] len_a [N];

    logic          rr_found;
    logic [GW-1:0] rr_pick;
    logic [GW:0]   rr_sum;

    logic          fifo_empty;
    logic          fifo_full;
    logic          tag_push;
    logic          tag_pop;
    logic          rsp_hit;
    logic [GW-1:0] head_tag;

    // Split the flat per-channel buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign adr_a[gi] = m_adr[gi*AW +: AW];
            assign len_a[gi] = m_len[gi*LW +: LW];
        end
    endgenerate

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (OW+1)'(DEPTH));
    assign head_tag   = tag_mem[rd_ptr_q];
    assign tag_push   = s_val & s_rdy & s_sob;
    assign rsp_hit    = s_rsp_val & ~fifo_empty;
    assign tag_pop    = rsp_hit & (rsp_cnt_q == '1);
    assign busy       = (state_q == ST_LOCK) | ~fifo_empty;
    assign err        = err_q;

    // Round-robin search: first requester strictly after last_q, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_sum   = '0;
        for (int k = 1; k <= N; k++) begin
            rr_sum = {1'b0, last_q} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(N)) begin
                rr_sum = rr_sum - (GW+1)'(N);
            end
            if (!rr_found && m_val[rr_sum[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_sum[GW-1:0];
            end
        end
    end

    // Arbitration FSM: grant in IDLE, transparent mux of the owner in LOCK.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        s_adr   = '0;
        s_len   = '0;
        s_sob   = 1'b0;
        s_eob   = 1'b0;
        s_val   = 1'b0;
        m_rdy   = '0;
        case (state_q)
            ST_IDLE: begin
                // A full tag FIFO blocks the grant, so the tag of a locked
                // burst always has a free slot waiting for it.
                if (rr_found && !fifo_full) begin
                    gnt_d   = rr_pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                s_adr        = adr_a[gnt_q];
                s_len        = len_a[gnt_q];
                s_sob        = m_sob[gnt_q];
                s_eob        = m_eob[gnt_q];
                s_val        = m_val[gnt_q];
                m_rdy[gnt_q] = s_rdy;
                if (m_val[gnt_q] && s_rdy && m_eob[gnt_q]) begin
                    state_d = ST_IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag FIFO pointers, level, response beat counter and sticky error.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        if (tag_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tag_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({tag_push, tag_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Counter wraps on its own after 2**BL beats, in step with the pop.
        if (rsp_hit) begin
            rsp_cnt_d = rsp_cnt_q + 1'b1;
        end
        if (s_rsp_val && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // Steer each response beat to the owner of the oldest outstanding burst.
    always_comb begin
        m_rsp_val = '0;
        if (rsp_hit) begin
            m_rsp_val[head_tag] = 1'b1;
        end
    end

    // Control state registers; reset abandons any burst and drops all tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            last_q    <= GW'(N - 1);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

    // Tag storage write; entries are only read while level_q marks them valid.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[wr_ptr_q] <= gnt_q;
        end
    end

endmodule

// File: tb/tb_xlib_dma_rc_arb.sv
// tb_xlib_dma_rc_arb
// Random DMA masters and a random bus slave drive the arbiter; a negedge
// monitor holds a reference of who must own the bus and which channel each
// response beat belongs to, and scores every cycle against it.
module tb_xlib_dma_rc_arb;

    localparam int N         = 2;
    localparam int AW        = 16;
    localparam int BL        = 2;
    localparam int BLEN_TYPE = 0;
    localparam int OW        = 1;
    localparam int LW        = BL - BLEN_TYPE + 1;
    localparam int BEATS     = 2 ** BL;
    localparam int DEPTH     = 2 ** OW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   m_adr;
    logic [N*LW-1:0]   m_len;
    logic [N-1:0]      m_sob, m_eob, m_val, m_rdy, m_rsp_val;
    logic [AW-1:0]     s_adr;
    logic [LW-1:0]     s_len;
    logic              s_sob, s_eob, s_val, s_rdy, s_rsp_val, busy, err;

    xlib_dma_rc_arb #(
        .N(N), .AW(AW), .BL(BL), .BLEN_TYPE(BLEN_TYPE), .OW(OW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_len(m_len), .m_sob(m_sob), .m_eob(m_eob),
        .m_val(m_val), .m_rdy(m_rdy), .m_rsp_val(m_rsp_val),
        .s_adr(s_adr), .s_len(s_len), .s_sob(s_sob), .s_eob(s_eob),
        .s_val(s_val), .s_rdy(s_rdy), .s_rsp_val(s_rsp_val),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [LW-1:0] len;
        logic          sob;
        logic          eob;
    } beat_t;

    // Expected command beats per channel, pushed when a master issues a burst.
    beat_t exp_beat_q [N][$];

    // Master/slave stimulus state.
    logic [N-1:0]  pend;
    int            beat [N];
    logic [AW-1:0] base [N];
    logic [LW-1:0] blen [N];
    logic [N-1:0]  req_en;
    int            req_pct, rdy_pct, rsp_pct, gap_pct;
    logic          rsp_en, force_rsp;
    int            drv_timeouts;

    // Reference model and scoreboard state (monitor-owned).
    logic [N-1:0]  hs;
    int            total, bad;
    logic          mdl_lock;
    int            mdl_owner, mdl_last, mdl_rcnt;
    logic          mdl_err;
    int            rsp_owner_q [$];
    int            timeouts_seen;
    int            tags_pre, m_pick;
    logic [N-1:0]  m_exp_rdy, m_exp_rsp;
    logic          m_exp_sval;
    beat_t         m_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs against the model, then advance the model to
    // what the coming rising edge does.
    initial begin
        total = 0; bad = 0; timeouts_seen = 0; hs = '0;
        mdl_lock = 1'b0; mdl_owner = 0; mdl_last = N - 1; mdl_rcnt = 0; mdl_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_lock  = 1'b0;
                mdl_owner = 0;
                mdl_last  = N - 1;
                mdl_rcnt  = 0;
                mdl_err   = 1'b0;
                rsp_owner_q.delete();
                hs        = '0;
            end else begin
                tags_pre   = rsp_owner_q.size();
                m_exp_rdy  = '0;
                if (mdl_lock) m_exp_rdy[mdl_owner] = s_rdy;
                m_exp_sval = mdl_lock && m_val[mdl_owner];
                chk("s_val", 64'(s_val), 64'(m_exp_sval));
                chk("m_rdy", 64'(m_rdy), 64'(m_exp_rdy));
                chk("busy", 64'(busy), 64'(mdl_lock || tags_pre != 0));
                chk("err", 64'(err), 64'(mdl_err));

                // Response routing: oldest outstanding burst owns the beat.
                m_exp_rsp = '0;
                if (s_rsp_val) begin
                    if (tags_pre != 0) begin
                        m_exp_rsp[rsp_owner_q[0]] = 1'b1;
                        mdl_rcnt++;
                        if (mdl_rcnt == BEATS) begin
                            $display("rsp burst done ch%0d at %0t", rsp_owner_q[0], $time);
                            void'(rsp_owner_q.pop_front());
                            mdl_rcnt = 0;
                        end
                    end else begin
                        mdl_err = 1'b1;
                    end
                end
                chk("m_rsp_val", 64'(m_rsp_val), 64'(m_exp_rsp));

                // Command side: owner beats pass through; otherwise arbitrate.
                if (mdl_lock) begin
                    if (m_exp_sval && s_rdy) begin
                        if (exp_beat_q[mdl_owner].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL beat at %0t: got an accepted beat on ch%0d expected none pending", $time, mdl_owner);
                        end else begin
                            m_beat = exp_beat_q[mdl_owner].pop_front();
                            chk("beat", 64'({s_adr, s_len, s_sob, s_eob}), 64'(m_beat));
                            if (m_beat.sob) begin
                                rsp_owner_q.push_back(mdl_owner);
                                $display("burst issued ch%0d adr=%h at %0t", mdl_owner, m_beat.adr, $time);
                            end
                            if (m_beat.eob) begin
                                mdl_lock = 1'b0;
                                mdl_last = mdl_owner;
                            end
                        end
                    end
                end else if (m_val != '0 && tags_pre < DEPTH) begin
                    m_pick = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (m_pick < 0 && m_val[(mdl_last + k) % N]) m_pick = (mdl_last + k) % N;
                    end
                    mdl_owner = m_pick;
                    mdl_lock  = 1'b1;
                end
                hs = m_val & m_rdy;
            end
            if (drv_timeouts != timeouts_seen) begin
                total++;
                bad++;
                $display("FAIL progress at %0t: got %0d stalls expected 0", $time, drv_timeouts - timeouts_seen);
                timeouts_seen = drv_timeouts;
            end
        end
    end

    // One stimulus cycle: retire handshaken beats, start new bursts, drive.
    task automatic step();
        beat_t nb;
        int    owed;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (beat[i] == BEATS - 1) pend[i] = 1'b0;
                else beat[i] = beat[i] + 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && req_en[i] && ($urandom_range(99) < req_pct)) begin
                pend[i] = 1'b1;
                beat[i] = 0;
                base[i] = AW'($urandom);
                // The arbiter forwards len untouched, so any value exercises the mux.
                blen[i] = LW'($urandom);
                for (int b = 0; b < BEATS; b++) begin
                    nb.adr = base[i] + AW'(b);
                    nb.len = blen[i];
                    nb.sob = (b == 0);
                    nb.eob = (b == BEATS - 1);
                    exp_beat_q[i].push_back(nb);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_val[i]            = pend[i] && !(beat[i] > 0 && $urandom_range(99) < gap_pct);
            m_adr[i*AW +: AW]   = base[i] + AW'(beat[i]);
            m_len[i*LW +: LW]   = blen[i];
            m_sob[i]            = (beat[i] == 0);
            m_eob[i]            = (beat[i] == BEATS - 1);
        end
        s_rdy = ($urandom_range(99) < rdy_pct);
        owed  = rsp_owner_q.size() * BEATS - mdl_rcnt;
        s_rsp_val = force_rsp || (rsp_en && owed > 0 && ($urandom_range(99) < rsp_pct));
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_pct = 0; rsp_en = 1'b1; rsp_pct = 100; rdy_pct = 100; gap_pct = 0;
        while ((pend != '0 || mdl_lock || rsp_owner_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (pend != '0 || mdl_lock || rsp_owner_q.size() != 0) drv_timeouts++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        pend      = '0;
        m_val     = '0;
        s_rsp_val = 1'b0;
        for (int i = 0; i < N; i++) exp_beat_q[i].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        m_adr = '0; m_len = '0; m_sob = '0; m_eob = '0; m_val = '0;
        s_rdy = 1'b0; s_rsp_val = 1'b0;
        pend = '0; req_en = '0; req_pct = 0; rdy_pct = 100; rsp_pct = 100; gap_pct = 0;
        rsp_en = 1'b1; force_rsp = 1'b0; drv_timeouts = 0;
        for (int i = 0; i < N; i++) begin
            beat[i] = 0; base[i] = '0; blen[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone ch0 burst with an always-ready bus.
        req_en = 2'b01; req_pct = 100;
        step();
        req_pct = 0;
        repeat (20) step();

        // Both channels request continuously: strict alternation.
        req_en = 2'b11; req_pct = 100;
        repeat (40) step();
        drain();

        // No responses: only DEPTH bursts may issue, then one drained burst frees a grant.
        req_en = 2'b11; req_pct = 100; rsp_en = 1'b0;
        repeat (30) step();
        rsp_en = 1'b1; rsp_pct = 100;
        repeat (30) step();
        drain();

        // Toggling bus ready with both channels pending.
        req_en = 2'b11; req_pct = 100; rdy_pct = 50; rsp_pct = 70;
        repeat (80) step();

        // Fully random traffic including mid-burst m_val drops.
        req_pct = 40; rdy_pct = 60; rsp_pct = 50; gap_pct = 30;
        repeat (700) step();
        drain();

        // Response with nothing outstanding sets the sticky error.
        force_rsp = 1'b1;
        step();
        force_rsp = 1'b0;
        repeat (3) step();

        // Reset in the middle of a burst.
        req_en = 2'b11; req_pct = 100; rdy_pct = 100; rsp_pct = 50;
        n = 0;
        while (!((pend[0] && beat[0] > 0) || (pend[1] && beat[1] > 0)) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) drv_timeouts++;
        do_reset();
        repeat (20) step();
        drain();

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
